mult_arbiter: RTL
=================

# mult_arbiter

Two-port round-robin arbiter and sequencer that shares one 16x16 sequential multiplier (`mult_32`) between two requesters, e.g. the core's M-extension unit and the address-generation helper. Each request is granted and its operands are latched. The arbiter then launches the multiplier with an `init` pulse, waits for `done`, and returns the 32-bit product to the winning requester. A timeout watchdog recovers a hung multiplier with an error response and a local multiplier reset.

## Interface
Parameters:
- `INIT_CYCLES`, default 2: number of cycles `m_init` is held high per launch (≥1).
- `TIMEOUT`, default 64: WAIT cycles allowed before abort (≥ 20).

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `req0` / `req1` in 1: request; held high with operands stable until the matching grant.
- `a0`, `b0` / `a1`, `b1` in 16 each: operands for requesters 0 / 1.
- `gnt0` / `gnt1` out 1: one-cycle pulse; operands were latched at the preceding edge.
- `rvalid0` / `rvalid1` out 1: one-cycle result pulse. No backpressure.
- `rdata0` / `rdata1` out 32: product. Valid when the matching `rvalid` is high, else 0.
- `rerr0` / `rerr1` out 1: high with `rvalid` on timeout abort.
- `busy` out 1: high in any state other than IDLE.
- `m_init` out 1: multiplier `init`.
- `m_rst` out 1: multiplier `rst` = `rst` OR registered abort pulse.
- `m_A`, `m_B` out 16: operands to the multiplier, held from launch until return to IDLE.
- `m_done` in 1: multiplier `done`.
- `m_pp` in 32: multiplier product.

## Operation
- States:
  - IDLE → LAUNCH on any sampled request.
  - LAUNCH → WAIT after `INIT_CYCLES` cycles.
  - WAIT → RESP on a `m_done` rising edge, or on timeout.
  - RESP → IDLE after 1 cycle.
- Arbitration is evaluated only in IDLE:
  - Single request: that requester wins.
  - Both requesting: the requester not served last wins.
  - `last` pointer resets to 1, so requester 0 wins the first tie. `last` updates at grant.
- IDLE edge with a request:
  - Latch the winner's A/B into `m_A`/`m_B`, record the owner.
  - Next cycle: `gntN` = 1 and `m_init` = 1.
- LAUNCH:
  - `m_init` stays high for exactly `INIT_CYCLES` cycles; `gnt` only in the first.
  - Operands are frozen from this point.
- WAIT:
  - `done_q` is the registered `m_done`. Completion = `m_done & ~done_q` sampled at an edge.
  - A `done` level already high on entry to WAIT is ignored; only a fresh 0→1 transition completes.
  - Product is captured from `m_pp` at the completion edge.
- Timeout:
  - Counter cleared on entry to WAIT, incremented each WAIT cycle.
  - Reaching `TIMEOUT` without completion → RESP with `rdata` = 0, `rerrN` = 1.
  - `m_rst` pulses high for the one RESP cycle.
- RESP: owner's `rvalidN` = 1 with captured data. The other port's `rvalid`/`rdata`/`rerr` stay 0.
- Requests arriving during `busy` are not acknowledged. They stay pending and are arbitrated at the next IDLE edge.
- Arithmetic: no modification of `m_pp`. The product is the unsigned 16x16 result, full 32 bits.

## Timing
- Reset values: state IDLE, `last` = 1, all `gnt`/`rvalid`/`rerr`/`rdata` = 0, `m_init` = 0, `m_A`/`m_B` = 0, `busy` = 0, counter 0, `done_q` = 0. `m_rst` = 1 while `rst` is high.
- Request sampled at edge E0:
  - `gnt` and `m_init` high in cycle E0+1.
  - `m_init` low from E0+1+`INIT_CYCLES`.
- Done edge sampled at Ed → `rvalid` high in cycle Ed+1.
  - IDLE again at Ed+2; next grant no earlier than Ed+3.
- `rst` asserted mid-operation (any state): return to IDLE at the next edge with no `rvalid` issued.
  - The in-flight request is dropped.
  - A still-held `req` is re-arbitrated after reset deasserts.
- `rst` and a completion on the same edge: reset wins.
- Same-edge events:
  - `req` deasserted in the same edge as a would-be grant: no grant, because arbitration uses the sampled value.

## Test plan
- Single request: req0, A = 0x00F7, B = 0x007F, behavioural 17-cycle mult model.
  - Required: `gnt0` pulse, `m_init` high 2 cycles, `rvalid0` with `rdata0` = 0x00007A89, `rerr0` = 0, `busy` low 2 cycles later.
- Tie after reset: req0 (3×5) and req1 (0xFFFF×0xFFFF) raised at the same edge.
  - Required: requester 0 served first with 0x0000000F, then requester 1 with 0xFFFE0001.
  - Exactly one `rvalid` per port.
- Fairness: both requests held high continuously for 4 transactions.
  - Required: grants alternate 1,0,1,0 (after the initial 0).
- Timeout: multiplier stub never raises `done`.
  - Required: after 64 WAIT cycles, `rvalid0` = 1, `rerr0` = 1, `rdata0` = 0, `m_rst` high for exactly 1 cycle.
- Stale done: stub holds `m_done` high from before launch, then drops it and re-raises it after 5 cycles.
  - Required: completion only on the re-raise; product is captured at that edge.
- Reset mid-WAIT: `rst` asserted for 1 cycle during WAIT.
  - Required: no `rvalid` for the aborted request, all outputs at reset values.
  - The held `req1` is granted 1 cycle after `rst` deasserts.

Source files
------------

// File: rtl/mult_arbiter.sv
// Two-port round-robin arbiter and sequencer sharing one sequential 16x16 multiplier.
// Grants a requester, launches the multiplier, and returns the product or a timeout error.
module mult_arbiter #(
    parameter int unsigned INIT_CYCLES = 2,
    parameter int unsigned TIMEOUT     = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0,
    input  logic        req1,
    input  logic [15:0] a0,
    input  logic [15:0] b0,
    input  logic [15:0] a1,
    input  logic [15:0] b1,
    output logic        gnt0,
    output logic        gnt1,
    output logic        rvalid0,
    output logic        rvalid1,
    output logic [31:0] rdata0,
    output logic [31:0] rdata1,
    output logic        rerr0,
    output logic        rerr1,
    output logic        busy,
    output logic        m_init,
    output logic        m_rst,
    output logic [15:0] m_A,
    output logic [15:0] m_B,
    input  logic        m_done,
    input  logic [31:0] m_pp
);

    localparam int unsigned LCNT_W = (INIT_CYCLES > 1) ? $clog2(INIT_CYCLES) : 1;
    localparam int unsigned TCNT_W = $clog2(TIMEOUT);
    localparam logic [LCNT_W-1:0] LCNT_LAST = LCNT_W'(INIT_CYCLES - 1);
    localparam logic [TCNT_W-1:0] TCNT_LAST = TCNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LAUNCH = 2'd1,
        S_WAIT   = 2'd2,
        S_RESP   = 2'd3
    } state_e;

    state_e              state_q;
    logic                last_q;
    logic                owner_q;
    logic                done_q;
    logic                abort_q;
    logic [LCNT_W-1:0]   lcnt_q;
    logic [TCNT_W-1:0]   tcnt_q;
    logic [15:0]         m_a_q;
    logic [15:0]         m_b_q;
    logic                gnt0_q;
    logic                gnt1_q;
    logic                rvalid0_q;
    logic                rvalid1_q;
    logic [31:0]         rdata0_q;
    logic [31:0]         rdata1_q;
    logic                rerr0_q;
    logic                rerr1_q;
    logic                busy_q;
    logic                m_init_q;

    logic                any_req_d;
    logic                win_d;
    logic                done_rise_d;
    logic                tmo_d;

    // Winner selection: on a tie the requester not served last takes the slot.
    always_comb begin
        any_req_d = req0 | req1;
        win_d     = 1'b0;
        if (req0 && req1) begin
            win_d = ~last_q;
        end else if (req1) begin
            win_d = 1'b1;
        end
    end

    // Only a fresh 0->1 on done counts; a level carried into WAIT is ignored.
    assign done_rise_d = m_done & ~done_q;
    assign tmo_d       = (tcnt_q == TCNT_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            last_q    <= 1'b1;
            owner_q   <= 1'b0;
            done_q    <= 1'b0;
            abort_q   <= 1'b0;
            lcnt_q    <= '0;
            tcnt_q    <= '0;
            m_a_q     <= '0;
            m_b_q     <= '0;
            gnt0_q    <= 1'b0;
            gnt1_q    <= 1'b0;
            rvalid0_q <= 1'b0;
            rvalid1_q <= 1'b0;
            rdata0_q  <= '0;
            rdata1_q  <= '0;
            rerr0_q   <= 1'b0;
            rerr1_q   <= 1'b0;
            busy_q    <= 1'b0;
            m_init_q  <= 1'b0;
        end else begin
            done_q <= m_done;
            case (state_q)
                S_IDLE: begin
                    if (any_req_d) begin
                        state_q  <= S_LAUNCH;
                        busy_q   <= 1'b1;
                        owner_q  <= win_d;
                        last_q   <= win_d;
                        m_a_q    <= win_d ? a1 : a0;
                        m_b_q    <= win_d ? b1 : b0;
                        gnt0_q   <= ~win_d;
                        gnt1_q   <= win_d;
                        m_init_q <= 1'b1;
                        lcnt_q   <= LCNT_LAST;
                    end
                end
                S_LAUNCH: begin
                    gnt0_q <= 1'b0;
                    gnt1_q <= 1'b0;
                    if (lcnt_q == '0) begin
                        state_q  <= S_WAIT;
                        m_init_q <= 1'b0;
                        tcnt_q   <= '0;
                    end else begin
                        lcnt_q <= lcnt_q - LCNT_W'(1);
                    end
                end
                S_WAIT: begin
                    // Completion takes priority over a timeout landing on the same edge.
                    if (done_rise_d || tmo_d) begin
                        state_q   <= S_RESP;
                        rvalid0_q <= ~owner_q;
                        rvalid1_q <= owner_q;
                        rdata0_q  <= (!owner_q && done_rise_d) ? m_pp : '0;
                        rdata1_q  <= (owner_q && done_rise_d) ? m_pp : '0;
                        rerr0_q   <= ~owner_q & ~done_rise_d;
                        rerr1_q   <= owner_q & ~done_rise_d;
                        abort_q   <= ~done_rise_d;
                    end else begin
                        tcnt_q <= tcnt_q + TCNT_W'(1);
                    end
                end
                S_RESP: begin
                    state_q   <= S_IDLE;
                    busy_q    <= 1'b0;
                    rvalid0_q <= 1'b0;
                    rvalid1_q <= 1'b0;
                    rdata0_q  <= '0;
                    rdata1_q  <= '0;
                    rerr0_q   <= 1'b0;
                    rerr1_q   <= 1'b0;
                    abort_q   <= 1'b0;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign gnt0    = gnt0_q;
    assign gnt1    = gnt1_q;
    assign rvalid0 = rvalid0_q;
    assign rvalid1 = rvalid1_q;
    assign rdata0  = rdata0_q;
    assign rdata1  = rdata1_q;
    assign rerr0   = rerr0_q;
    assign rerr1   = rerr1_q;
    assign busy    = busy_q;
    assign m_init  = m_init_q;
    assign m_A     = m_a_q;
    assign m_B     = m_b_q;
    // Multiplier is held in reset by the system reset or for the single abort cycle.
    assign m_rst   = rst | abort_q;

endmodule
